// File: rtl/cpu_exc_pkg.sv
// Shared exception constants: Cause codes and arbiter state encoding.
// The Cause decoder imports these same definitions.
package cpu_exc_pkg;

    localparam logic [1:0] CAUSE_INT = 2'b00;
    localparam logic [1:0] CAUSE_SYS = 2'b01;
    localparam logic [1:0] CAUSE_ILL = 2'b10;
    localparam logic [1:0] CAUSE_OVF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } exc_state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Vectorised multi-flop synchroniser with one-cycle rising-edge pulse
// per asynchronous interrupt line.
module int_sync_edge #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] rise
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  prev_d;

    // Shift chain next-state and edge detect against the extra history flop.
    always_comb begin
        sync_d[0] = async_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/exception_arbiter.sv
// Prioritises synchronous exceptions and pending interrupts, latches one cause
// plus EPC, and runs the request/service handshake with the pipeline controller.
module exception_arbiter
    import cpu_exc_pkg::*;
#(
    parameter int NUM_INT     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_INT-1:0] ext_int,
    input  logic               ie,
    input  logic               instr_valid,
    input  logic [31:0]        pc_in,
    input  logic               ovf,
    input  logic               ill,
    input  logic               sys,
    input  logic               exc_ack,
    input  logic               eret,
    output logic               exc_req,
    output logic [1:0]         cause,
    output logic [31:0]        epc,
    output logic [2:0]         int_id,
    output logic               in_handler,
    output logic               dbl_fault
);

    exc_state_e         state_q, state_d;
    logic [1:0]         cause_q, cause_d;
    logic [31:0]        epc_q, epc_d;
    logic [2:0]         int_id_q, int_id_d;
    logic               dbl_fault_q, dbl_fault_d;
    logic [NUM_INT-1:0] int_pend_q, int_pend_d;
    logic [NUM_INT-1:0] int_rise_s;
    logic [NUM_INT-1:0] int_clr_s;
    logic [7:0]         pend8_s;
    logic [2:0]         pick_s;

    int_sync_edge #(
        .WIDTH       (NUM_INT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_int),
        .rise     (int_rise_s)
    );

    // Priority select, FSM next state, latch of cause/EPC/int_id, pending bookkeeping.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        int_id_d    = int_id_q;
        dbl_fault_d = dbl_fault_q;
        int_clr_s   = '0;
        pend8_s     = 8'd0;
        pend8_s[NUM_INT-1:0] = int_pend_q;
        pick_s      = lowest_set(pend8_s);

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (ovf) begin
                        state_d = ST_REQ;
                        cause_d = CAUSE_OVF;
                        epc_d   = pc_in;
                    end else if (ill) begin
                        state_d = ST_REQ;
                        cause_d = CAUSE_ILL;
                        epc_d   = pc_in;
                    end else if (sys) begin
                        state_d = ST_REQ;
                        cause_d = CAUSE_SYS;
                        epc_d   = pc_in;
                    end else if (ie && (|int_pend_q)) begin
                        state_d  = ST_REQ;
                        cause_d  = CAUSE_INT;
                        epc_d    = pc_in;
                        int_id_d = pick_s;
                        for (int i = 0; i < NUM_INT; i++) begin
                            int_clr_s[i] = (3'(i) == pick_s);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (exc_ack) begin
                    state_d = ST_SERVICE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A synchronous fault while busy cannot be serviced; record it sticky.
        if ((state_q != ST_IDLE) && instr_valid && (ovf || ill || sys)) begin
            dbl_fault_d = 1'b1;
        end else begin
            dbl_fault_d = dbl_fault_q;
        end

        // New edges win over a same-cycle clear.
        int_pend_d = (int_pend_q & ~int_clr_s) | int_rise_s;
    end

    // State, latched cause/EPC and pending-interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cause_q     <= CAUSE_INT;
            epc_q       <= 32'd0;
            int_id_q    <= 3'd0;
            dbl_fault_q <= 1'b0;
            int_pend_q  <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            int_id_q    <= int_id_d;
            dbl_fault_q <= dbl_fault_d;
            int_pend_q  <= int_pend_d;
        end
    end

    assign exc_req    = (state_q == ST_REQ);
    assign in_handler = (state_q == ST_SERVICE);
    assign cause      = cause_q;
    assign epc        = epc_q;
    assign int_id     = int_id_q;
    assign dbl_fault  = dbl_fault_q;

endmodule

// File: tb/tb_exception_arbiter.sv
// Directed self-checking bench for exception_arbiter; inputs change and
// outputs are sampled on the falling clock edge.
module tb_exception_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ext_int;
    logic        ie;
    logic        instr_valid;
    logic [31:0] pc_in;
    logic        ovf;
    logic        ill;
    logic        sys;
    logic        exc_ack;
    logic        eret;
    logic        exc_req;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [2:0]  int_id;
    logic        in_handler;
    logic        dbl_fault;

    int checks;
    int failures;

    exception_arbiter #(
        .NUM_INT     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ext_int     (ext_int),
        .ie          (ie),
        .instr_valid (instr_valid),
        .pc_in       (pc_in),
        .ovf         (ovf),
        .ill         (ill),
        .sys         (sys),
        .exc_ack     (exc_ack),
        .eret        (eret),
        .exc_req     (exc_req),
        .cause       (cause),
        .epc         (epc),
        .int_id      (int_id),
        .in_handler  (in_handler),
        .dbl_fault   (dbl_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        ext_int = 4'd0;
        ie = 1'b0;
        instr_valid = 1'b0;
        pc_in = 32'd0;
        ovf = 1'b0;
        ill = 1'b0;
        sys = 1'b0;
        exc_ack = 1'b0;
        eret = 1'b0;

        // Reset state
        step(2);
        chk("rst_exc_req", {31'd0, exc_req}, 32'd0);
        chk("rst_cause", {30'd0, cause}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_int_id", {29'd0, int_id}, 32'd0);
        chk("rst_in_handler", {31'd0, in_handler}, 32'd0);
        chk("rst_dbl_fault", {31'd0, dbl_fault}, 32'd0);
        rst_n = 1'b1;

        // Stray ack in IDLE is ignored
        step(1);
        exc_ack = 1'b1;
        step(1);
        exc_ack = 1'b0;
        chk("idle_ack_req", {31'd0, exc_req}, 32'd0);
        chk("idle_ack_hdl", {31'd0, in_handler}, 32'd0);

        // Overflow beats illegal
        instr_valid = 1'b1;
        pc_in = 32'h0040_0010;
        ovf = 1'b1;
        ill = 1'b1;
        step(1);
        instr_valid = 1'b0;
        ovf = 1'b0;
        ill = 1'b0;
        chk("ovf_req", {31'd0, exc_req}, 32'd1);
        chk("ovf_cause", {30'd0, cause}, 32'd3);
        chk("ovf_epc", epc, 32'h0040_0010);
        chk("ovf_hdl_low", {31'd0, in_handler}, 32'd0);
        exc_ack = 1'b1;
        step(1);
        exc_ack = 1'b0;
        chk("ack_req_drop", {31'd0, exc_req}, 32'd0);
        chk("ack_hdl", {31'd0, in_handler}, 32'd1);
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        chk("eret_hdl", {31'd0, in_handler}, 32'd0);
        chk("eret_cause_hold", {30'd0, cause}, 32'd3);

        // Single interrupt through the synchroniser
        ext_int = 4'b0100;
        ie = 1'b1;
        instr_valid = 1'b1;
        pc_in = 32'h0040_0020;
        step(3);
        chk("int2_not_yet", {31'd0, exc_req}, 32'd0);
        step(1);
        chk("int2_req", {31'd0, exc_req}, 32'd1);
        chk("int2_cause", {30'd0, cause}, 32'd0);
        chk("int2_id", {29'd0, int_id}, 32'd2);
        chk("int2_epc", epc, 32'h0040_0020);
        chk("int2_pend_clr", {28'd0, dut.int_pend_q}, 32'd0);
        instr_valid = 1'b0;
        exc_ack = 1'b1;
        step(1);
        exc_ack = 1'b0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        ext_int = 4'b0000;
        step(4);

        // Two interrupts held off by ie=0, lowest index first
        ext_int = 4'b1010;
        ie = 1'b0;
        instr_valid = 1'b1;
        pc_in = 32'h0000_0100;
        step(10);
        chk("ie0_no_req", {31'd0, exc_req}, 32'd0);
        ie = 1'b1;
        step(1);
        chk("int1_req", {31'd0, exc_req}, 32'd1);
        chk("int1_id", {29'd0, int_id}, 32'd1);
        chk("int1_epc", epc, 32'h0000_0100);
        chk("int3_still_pend", {28'd0, dut.int_pend_q}, 32'h8);
        instr_valid = 1'b0;
        exc_ack = 1'b1;
        step(1);
        exc_ack = 1'b0;

        // Syscall in SERVICE: double fault, no new request
        instr_valid = 1'b1;
        pc_in = 32'h0000_0ABC;
        sys = 1'b1;
        step(1);
        instr_valid = 1'b0;
        sys = 1'b0;
        chk("dbl_set", {31'd0, dbl_fault}, 32'd1);
        chk("dbl_no_req", {31'd0, exc_req}, 32'd0);
        chk("dbl_cause", {30'd0, cause}, 32'd0);
        chk("dbl_epc", epc, 32'h0000_0100);
        chk("dbl_hdl", {31'd0, in_handler}, 32'd1);
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        instr_valid = 1'b1;
        pc_in = 32'h0000_0200;
        step(1);
        instr_valid = 1'b0;
        chk("int3_req", {31'd0, exc_req}, 32'd1);
        chk("int3_id", {29'd0, int_id}, 32'd3);
        chk("int3_epc", epc, 32'h0000_0200);
        chk("dbl_sticky", {31'd0, dbl_fault}, 32'd1);
        exc_ack = 1'b1;
        step(1);
        exc_ack = 1'b0;

        // Event coinciding with eret is not taken
        eret = 1'b1;
        instr_valid = 1'b1;
        ill = 1'b1;
        step(1);
        eret = 1'b0;
        instr_valid = 1'b0;
        ill = 1'b0;
        chk("eret_evt_hdl", {31'd0, in_handler}, 32'd0);
        step(1);
        chk("eret_evt_no_req", {31'd0, exc_req}, 32'd0);
        ext_int = 4'b0000;
        step(2);

        // Pending interrupt waits for a valid instruction
        ext_int = 4'b0001;
        step(8);
        chk("noval_no_req", {31'd0, exc_req}, 32'd0);
        chk("noval_pend", {28'd0, dut.int_pend_q}, 32'd1);
        instr_valid = 1'b1;
        pc_in = 32'h0000_0300;
        step(1);
        instr_valid = 1'b0;
        chk("int0_req", {31'd0, exc_req}, 32'd1);
        chk("int0_id", {29'd0, int_id}, 32'd0);
        chk("int0_epc", epc, 32'h0000_0300);

        // Reset in the middle of REQ
        #2;
        rst_n = 1'b0;
        ext_int = 4'b0000;
        #1;
        chk("mrst_req", {31'd0, exc_req}, 32'd0);
        chk("mrst_epc", epc, 32'd0);
        chk("mrst_cause", {30'd0, cause}, 32'd0);
        chk("mrst_dbl", {31'd0, dbl_fault}, 32'd0);
        chk("mrst_hdl", {31'd0, in_handler}, 32'd0);
        step(1);
        rst_n = 1'b1;
        instr_valid = 1'b1;
        pc_in = 32'h0000_0400;
        step(5);
        chk("post_rst_no_req", {31'd0, exc_req}, 32'd0);
        instr_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
